// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the i/d-cache to main-memory arbiter.
package rv32i_types;
  localparam int LINE_WIDTH = 256;
  localparam int BEAT_WIDTH = 64;
  localparam int BURST_LEN  = 4;

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_BEAT, WR_BEAT, DONE} arb_state_t;
  typedef enum logic {I_REQ, D_REQ} arb_req_t;
endpackage

// File: rtl/cache_mem_arbiter_line_beat_buffer.sv
// One cache line held as BURST_LEN beats: parallel load, beat-indexed write and read.
module line_beat_buffer #(
  parameter int BEAT_WIDTH = 64,
  parameter int BURST_LEN  = 4,
  localparam int CNT_W     = $clog2(BURST_LEN)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_load,
  input  logic [BEAT_WIDTH*BURST_LEN-1:0] i_load_line,
  input  logic                            i_beat_we,
  input  logic [CNT_W-1:0]                i_beat_idx,
  input  logic [BEAT_WIDTH-1:0]           i_beat_data,
  output logic [BEAT_WIDTH*BURST_LEN-1:0] o_line,
  output logic [BEAT_WIDTH-1:0]           o_beat
);
  logic [BURST_LEN-1:0][BEAT_WIDTH-1:0] r_line;

  always_ff @(posedge clk) begin
    if (!rst)           r_line <= '0;
    else if (i_load)    r_line <= i_load_line;
    else if (i_beat_we) r_line[i_beat_idx] <= i_beat_data;
  end

  assign o_line = r_line;
  assign o_beat = r_line[i_beat_idx];
endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the burst memory port between i-cache and d-cache, one line at a time.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise the d-cache has fixed priority.
module cache_mem_arbiter #(
  parameter int BEAT_WIDTH = rv32i_types::BEAT_WIDTH,
  parameter int BURST_LEN  = rv32i_types::BURST_LEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [31:0]                     i_dfp_addr,
  input  logic                            i_dfp_read,
  input  logic                            i_dfp_write,
  input  logic [BEAT_WIDTH*BURST_LEN-1:0] i_dfp_wdata,
  output logic [BEAT_WIDTH*BURST_LEN-1:0] i_dfp_rdata,
  output logic                            i_dfp_resp,
  input  logic [31:0]                     d_dfp_addr,
  input  logic                            d_dfp_read,
  input  logic                            d_dfp_write,
  input  logic [BEAT_WIDTH*BURST_LEN-1:0] d_dfp_wdata,
  output logic [BEAT_WIDTH*BURST_LEN-1:0] d_dfp_rdata,
  output logic                            d_dfp_resp,
  output logic [31:0]                     bmem_addr,
  output logic                            bmem_read,
  output logic                            bmem_write,
  output logic [BEAT_WIDTH-1:0]           bmem_wdata,
  input  logic                            bmem_ready,
  input  logic [31:0]                     bmem_raddr,
  input  logic [BEAT_WIDTH-1:0]           bmem_rdata,
  input  logic                            bmem_rvalid
);
  import rv32i_types::*;

  localparam int LINE_W = BEAT_WIDTH * BURST_LEN;
  localparam int CNT_W  = $clog2(BURST_LEN);
  localparam int OFF_W  = $clog2(LINE_W / 8);

  arb_state_t         r_state, w_next;
  arb_req_t           r_grant, w_win;
  logic [31:0]        r_addr, w_win_addr;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_i_req, w_d_req, w_any_req, w_win_wr, w_last;
  logic               w_load, w_beat_we;
  logic [LINE_W-1:0]  w_win_wdata, w_line;
  logic [BEAT_WIDTH-1:0] w_beat;

  assign w_i_req   = i_dfp_read | i_dfp_write;
  assign w_d_req   = d_dfp_read | d_dfp_write;
  assign w_any_req = w_i_req | w_d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // r_rr_ptr names the cache that wins the next collision.
  arb_req_t r_rr_ptr;

  always_comb begin
    w_win = D_REQ;
    if (w_i_req && w_d_req) w_win = r_rr_ptr;
    else if (w_i_req)       w_win = I_REQ;
  end

  always_ff @(posedge clk) begin
    if (!rst)                            r_rr_ptr <= D_REQ;
    else if (r_state == IDLE && w_any_req) r_rr_ptr <= (w_win == D_REQ) ? I_REQ : D_REQ;
  end
`else
  assign w_win = w_d_req ? D_REQ : I_REQ;
`endif

  // Write beats read: a dirty line goes back before the refill.
  assign w_win_wr    = (w_win == D_REQ) ? d_dfp_write : i_dfp_write;
  assign w_win_addr  = (w_win == D_REQ) ? d_dfp_addr  : i_dfp_addr;
  assign w_win_wdata = (w_win == D_REQ) ? d_dfp_wdata : i_dfp_wdata;
  assign w_last      = (r_cnt == CNT_W'(BURST_LEN - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req)                w_next = w_win_wr ? WR_BEAT : RD_CMD;
      RD_CMD:  if (bmem_ready)               w_next = RD_BEAT;
      RD_BEAT: if (bmem_rvalid && w_last)    w_next = DONE;
      WR_BEAT: if (bmem_ready && w_last)     w_next = DONE;
      DONE:                                  w_next = IDLE;
      default:                               w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_grant <= I_REQ;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_any_req) begin
          r_grant <= w_win;
          r_addr  <= {w_win_addr[31:OFF_W], {OFF_W{1'b0}}};
          r_cnt   <= '0;
        end
        RD_BEAT: if (bmem_rvalid) r_cnt <= r_cnt + 1'b1;
        WR_BEAT: if (bmem_ready)  r_cnt <= r_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign w_load    = (r_state == IDLE) && w_any_req;
  assign w_beat_we = (r_state == RD_BEAT) && bmem_rvalid;

  line_beat_buffer #(.BEAT_WIDTH(BEAT_WIDTH), .BURST_LEN(BURST_LEN)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_line(w_win_wdata),
    .i_beat_we  (w_beat_we),
    .i_beat_idx (r_cnt),
    .i_beat_data(bmem_rdata),
    .o_line     (w_line),
    .o_beat     (w_beat)
  );

  assign bmem_read   = (r_state == RD_CMD);
  assign bmem_write  = (r_state == WR_BEAT);
  assign bmem_addr   = (bmem_read | bmem_write) ? r_addr : '0;
  assign bmem_wdata  = bmem_write ? w_beat : '0;
  assign i_dfp_resp  = (r_state == DONE) && (r_grant == I_REQ);
  assign d_dfp_resp  = (r_state == DONE) && (r_grant == D_REQ);
  assign i_dfp_rdata = w_line;
  assign d_dfp_rdata = w_line;

  logic w_unused_ok;
  assign w_unused_ok = ^{i_dfp_addr[OFF_W-1:0], d_dfp_addr[OFF_W-1:0], bmem_raddr};

`ifndef SYNTHESIS
  a_raddr: assert property (@(posedge clk) disable iff (!rst)
    (r_state == RD_BEAT && bmem_rvalid) |-> (bmem_raddr == r_addr));
  a_line_w: assert property (@(posedge clk) LINE_W == LINE_WIDTH);
`endif
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (default or ARB_ROUND_ROBIN_EN build).
module tb_cache_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  i_dfp_addr, d_dfp_addr, bmem_addr, bmem_raddr;
  logic         i_dfp_read, i_dfp_write, i_dfp_resp;
  logic         d_dfp_read, d_dfp_write, d_dfp_resp;
  logic [255:0] i_dfp_wdata, i_dfp_rdata, d_dfp_wdata, d_dfp_rdata;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_dfp_addr(i_dfp_addr), .i_dfp_read(i_dfp_read), .i_dfp_write(i_dfp_write),
    .i_dfp_wdata(i_dfp_wdata), .i_dfp_rdata(i_dfp_rdata), .i_dfp_resp(i_dfp_resp),
    .d_dfp_addr(d_dfp_addr), .d_dfp_read(d_dfp_read), .d_dfp_write(d_dfp_write),
    .d_dfp_wdata(d_dfp_wdata), .d_dfp_rdata(d_dfp_rdata), .d_dfp_resp(d_dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  function automatic logic [63:0] mk_beat(input logic [31:0] a, input int k);
    return {a, 24'hC0FFEE, 8'(k)};
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    return {mk_beat(a, 3), mk_beat(a, 2), mk_beat(a, 1), mk_beat(a, 0)};
  endfunction

  task automatic clear_inputs;
    i_dfp_addr = '0; i_dfp_read = 0; i_dfp_write = 0; i_dfp_wdata = '0;
    d_dfp_addr = '0; d_dfp_read = 0; d_dfp_write = 0; d_dfp_wdata = '0;
    bmem_ready = 0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 0;
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    rst = 0; clear_inputs();
    @(posedge clk); #1;
    rst = 1;
  endtask

  // Memory that is always ready and answers each read command with 4 beats
  // starting the cycle after the command. Returns at the first resp seen.
  task automatic run_auto(input int max_cyc, output int who, output int first_cmd,
                          output logic saw_rd, output logic saw_wr, output logic [255:0] line);
    int pend;
    logic [31:0] la;
    pend = 0; la = '0; who = -1; first_cmd = -1; saw_rd = 0; saw_wr = 0; line = '0;
    bmem_ready = 1;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk); #1;
      if (pend > 0) begin
        bmem_rvalid = 1; bmem_raddr = la; bmem_rdata = mk_beat(la, 4 - pend); pend--;
      end else bmem_rvalid = 0;
      @(negedge clk);
      if (bmem_read)  begin saw_rd = 1; pend = 4; la = bmem_addr; if (first_cmd < 0) first_cmd = c; end
      if (bmem_write) begin saw_wr = 1; if (first_cmd < 0) first_cmd = c; end
      if (i_dfp_resp || d_dfp_resp) begin
        who  = d_dfp_resp ? 1 : 0;
        line = d_dfp_resp ? d_dfp_rdata : i_dfp_rdata;
        break;
      end
    end
    bmem_rvalid = 0;
  endtask

  task automatic test_reset;
    rst = 0; clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bmem_read !== 0 || bmem_write !== 0 || bmem_addr !== 0 || bmem_wdata !== 0) begin
      errors++; $display("FAIL reset_bmem: got rd=%b wr=%b addr=%h wdata=%h, want all 0",
                         bmem_read, bmem_write, bmem_addr, bmem_wdata);
    end
    checks++;
    if (i_dfp_resp !== 0 || d_dfp_resp !== 0) begin
      errors++; $display("FAIL reset_resp: got i=%b d=%b, want 0 0", i_dfp_resp, d_dfp_resp);
    end
    checks++;
    if (i_dfp_rdata !== '0 || d_dfp_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata: got i=%h d=%h, want 0", i_dfp_rdata, d_dfp_rdata);
    end
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_d_read;
    logic [63:0]  bt [4];
    logic [255:0] want;
    int nrd, early;
    bt[0] = 64'h1111_1111_1111_1111; bt[1] = 64'h2222_2222_2222_2222;
    bt[2] = 64'h3333_3333_3333_3333; bt[3] = 64'h4444_4444_4444_4444;
    want  = 256'h4444_4444_4444_4444_3333_3333_3333_3333_2222_2222_2222_2222_1111_1111_1111_1111;
    nrd = 0; early = 0;
    d_dfp_addr = 32'h0000_1040; d_dfp_read = 1; bmem_ready = 1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bmem_read !== 1 || bmem_addr !== 32'h0000_1040) begin
      errors++; $display("FAIL rd_cmd: got rd=%b addr=%h, want 1 00001040", bmem_read, bmem_addr);
    end
    if (bmem_read) nrd++;
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      bmem_rvalid = 1; bmem_raddr = 32'h0000_1040; bmem_rdata = bt[b];
      @(negedge clk);
      if (bmem_read) nrd++;
      if (i_dfp_resp || d_dfp_resp) early++;
      @(posedge clk); #1;
    end
    bmem_rvalid = 0;
    @(negedge clk);
    checks++;
    if (d_dfp_resp !== 1 || i_dfp_resp !== 0 || early != 0) begin
      errors++; $display("FAIL rd_resp: got d=%b i=%b early=%0d, want 1 0 0", d_dfp_resp, i_dfp_resp, early);
    end
    checks++;
    if (d_dfp_rdata !== want) begin
      errors++; $display("FAIL rd_line: got %h want %h", d_dfp_rdata, want);
    end
    checks++;
    if (nrd != 1) begin
      errors++; $display("FAIL rd_cmd_count: got %0d want 1", nrd);
    end
    @(posedge clk); #1;
    d_dfp_read = 0;
    @(negedge clk);
    checks++;
    if (d_dfp_resp !== 0) begin
      errors++; $display("FAIL rd_resp_width: got %b want 0", d_dfp_resp);
    end
  endtask

  task automatic test_d_write_stall;
    logic [63:0]  wb [4];
    logic [255:0] lw;
    int idx;
    wb[0] = 64'hAAAA_AAAA_AAAA_0123; wb[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    wb[2] = 64'hCCCC_CCCC_CCCC_CCCC; wb[3] = 64'hDDDD_DDDD_DDDD_DDDD;
    lw = 256'hDDDD_DDDD_DDDD_DDDD_CCCC_CCCC_CCCC_CCCC_BBBB_BBBB_BBBB_BBBB_AAAA_AAAA_AAAA_0123;
    do_reset();
    d_dfp_addr = 32'h0000_2000; d_dfp_write = 1; d_dfp_wdata = lw; bmem_ready = 1;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      bmem_ready = !(n >= 3 && n <= 5);
      @(negedge clk);
      if (n <= 7) begin
        idx = (n == 1) ? 0 : (n == 2) ? 1 : (n <= 6) ? 2 : 3;
        checks++;
        if (bmem_write !== 1 || bmem_wdata !== wb[idx] || bmem_addr !== 32'h0000_2000 || d_dfp_resp !== 0) begin
          errors++; $display("FAIL wr_beat c%0d: got wr=%b data=%h addr=%h resp=%b, want 1 %h 00002000 0",
                             n, bmem_write, bmem_wdata, bmem_addr, d_dfp_resp, wb[idx]);
        end
      end else begin
        checks++;
        if (d_dfp_resp !== 1 || i_dfp_resp !== 0 || bmem_write !== 0) begin
          errors++; $display("FAIL wr_resp c8: got d=%b i=%b wr=%b, want 1 0 0", d_dfp_resp, i_dfp_resp, bmem_write);
        end
      end
    end
    @(posedge clk); #1;
    d_dfp_write = 0;
  endtask

  task automatic test_collision;
    int who, fc, exp_who;
    logic srd, swr;
    logic [255:0] ln;
    logic [31:0] exp_a;
    do_reset();
    i_dfp_addr = 32'h0000_301F; i_dfp_read = 1;
    d_dfp_addr = 32'h0000_4000; d_dfp_read = 1;
    run_auto(40, who, fc, srd, swr, ln);
    checks++;
    if (who != 1 || ln !== exp_line(32'h0000_4000)) begin
      errors++; $display("FAIL coll_first: got who=%0d line=%h, want 1 %h", who, ln, exp_line(32'h0000_4000));
    end
    d_dfp_addr = 32'h0000_4020;
`ifdef ARB_ROUND_ROBIN_EN
    exp_who = 0; exp_a = 32'h0000_3000;
`else
    exp_who = 1; exp_a = 32'h0000_4020;
`endif
    run_auto(40, who, fc, srd, swr, ln);
    checks++;
    if (who != exp_who || ln !== exp_line(exp_a)) begin
      errors++; $display("FAIL coll_second: got who=%0d line=%h, want %0d %h", who, ln, exp_who, exp_line(exp_a));
    end
    checks++;
    if (fc != 1) begin
      errors++; $display("FAIL back_to_back: got cmd at cycle %0d after resp, want 1", fc);
    end
    if (exp_who == 0) i_dfp_read = 0; else d_dfp_read = 0;
    exp_who = 1 - exp_who;
    exp_a   = (exp_who == 0) ? 32'h0000_3000 : 32'h0000_4020;
    run_auto(40, who, fc, srd, swr, ln);
    checks++;
    if (who != exp_who || ln !== exp_line(exp_a)) begin
      errors++; $display("FAIL coll_third: got who=%0d line=%h, want %0d %h", who, ln, exp_who, exp_line(exp_a));
    end
    i_dfp_read = 0; d_dfp_read = 0;
  endtask

  task automatic test_wb_alloc;
    int who, fc, exp_who;
    logic srd, swr;
    logic [255:0] ln;
    logic [31:0] exp_a;
    do_reset();
    i_dfp_addr = 32'h0000_5000; i_dfp_read = 1;
    d_dfp_addr = 32'h0000_6000; d_dfp_write = 1; d_dfp_read = 1;
    d_dfp_wdata = {4{64'h0F0F_F0F0_1234_5678}};
    run_auto(40, who, fc, srd, swr, ln);
    checks++;
    if (who != 1 || swr !== 1 || srd !== 0) begin
      errors++; $display("FAIL wb_first: got who=%0d wr=%b rd=%b, want 1 1 0", who, swr, srd);
    end
    d_dfp_write = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_who = 0; exp_a = 32'h0000_5000;
`else
    exp_who = 1; exp_a = 32'h0000_6000;
`endif
    run_auto(40, who, fc, srd, swr, ln);
    checks++;
    if (who != exp_who || srd !== 1 || ln !== exp_line(exp_a)) begin
      errors++; $display("FAIL wb_second: got who=%0d rd=%b line=%h, want %0d 1 %h", who, srd, ln, exp_who, exp_line(exp_a));
    end
    if (exp_who == 0) i_dfp_read = 0; else d_dfp_read = 0;
    exp_who = 1 - exp_who;
    exp_a   = (exp_who == 0) ? 32'h0000_5000 : 32'h0000_6000;
    run_auto(40, who, fc, srd, swr, ln);
    checks++;
    if (who != exp_who || ln !== exp_line(exp_a)) begin
      errors++; $display("FAIL wb_third: got who=%0d line=%h, want %0d %h", who, ln, exp_who, exp_line(exp_a));
    end
    i_dfp_read = 0; d_dfp_read = 0;
  endtask

  task automatic test_reset_mid;
    int who, fc, bad;
    logic srd, swr;
    logic [255:0] ln;
    do_reset();
    d_dfp_addr = 32'h0000_7000; d_dfp_read = 1; bmem_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bmem_rvalid = 1; bmem_raddr = 32'h0000_7000; bmem_rdata = 64'hDEAD_0000_0000_0000;
    @(posedge clk); #1;
    bmem_rdata = 64'hDEAD_0000_0000_0001;
    @(posedge clk); #1;
    bmem_rvalid = 0; rst = 0; d_dfp_read = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    checks++;
    if (bmem_read !== 0 || bmem_write !== 0 || bmem_addr !== 0 || bmem_wdata !== 0 ||
        d_dfp_resp !== 0 || i_dfp_resp !== 0 || d_dfp_rdata !== '0) begin
      errors++; $display("FAIL rst_mid: got rd=%b wr=%b addr=%h resp=%b rdata=%h, want all 0",
                         bmem_read, bmem_write, bmem_addr, d_dfp_resp, d_dfp_rdata);
    end
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (d_dfp_resp || i_dfp_resp || bmem_read || bmem_write) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rst_quiet: got %0d active cycles, want 0", bad);
    end
    d_dfp_addr = 32'h0000_7020; d_dfp_read = 1;
    run_auto(40, who, fc, srd, swr, ln);
    checks++;
    if (who != 1 || ln !== exp_line(32'h0000_7020)) begin
      errors++; $display("FAIL rst_after: got who=%0d line=%h, want 1 %h", who, ln, exp_line(32'h0000_7020));
    end
    d_dfp_read = 0;
  endtask

  task automatic test_spurious;
    int who, fc, bad, bad_line;
    logic srd, swr;
    logic [255:0] ln;
    do_reset();
    d_dfp_addr = 32'h0000_8000; d_dfp_read = 1;
    run_auto(40, who, fc, srd, swr, ln);
    d_dfp_read = 0;
    @(posedge clk); #1;
    bad = 0; bad_line = 0;
    for (int c = 0; c < 4; c++) begin
      bmem_rvalid = 1; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0; bmem_raddr = '0;
      @(negedge clk);
      if (d_dfp_resp || i_dfp_resp || bmem_read || bmem_write) bad++;
      if (d_dfp_rdata !== exp_line(32'h0000_8000)) bad_line++;
      @(posedge clk); #1;
    end
    bmem_rvalid = 0;
    checks++;
    if (bad != 0 || bad_line != 0) begin
      errors++; $display("FAIL spurious_rvalid: got active=%0d corrupt=%0d, want 0 0", bad, bad_line);
    end
    d_dfp_addr = 32'h0000_8040; d_dfp_read = 1;
    run_auto(40, who, fc, srd, swr, ln);
    checks++;
    if (who != 1 || ln !== exp_line(32'h0000_8040)) begin
      errors++; $display("FAIL spurious_after: got who=%0d line=%h, want 1 %h", who, ln, exp_line(32'h0000_8040));
    end
    d_dfp_read = 0;
  endtask

  initial begin
    test_reset();
    test_d_read();
    test_d_write_stall();
    test_collision();
    test_wb_alloc();
    test_reset_mid();
    test_spurious();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single burst-mode main-memory port between the instruction cache and the data cache. Each cache presents a 256-bit cache-line request on its dfp port, and the arbiter grants one request at a time. For the granted request it serializes or deserializes the line into 64-bit memory beats and returns a one-cycle `resp` to that cache only. It sits between `i_cache` / `d_cache` and the memory model / bus adapter at the top of the CPU.

## Interface
- `BEAT_WIDTH`, 64: memory data beat width in bits.
- `BURST_LEN`, 4: beats per cache line; `BEAT_WIDTH*BURST_LEN` must equal 256.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: one clock; reset is synchronous and active-low (`rst==0` resets on the next `clk` edge).
- `i_dfp_addr` in 32: i-cache line address; bits [4:0] are ignored.
- `i_dfp_read` in 1: i-cache line read request.
- `i_dfp_write` in 1: i-cache line write request (never used by the i-cache; arbitrated identically).
- `i_dfp_wdata` in 256: i-cache write line.
- `i_dfp_rdata` out 256: line returned to the i-cache.
- `i_dfp_resp` out 1: one-cycle completion pulse to the i-cache.
- `d_dfp_addr`, `d_dfp_read`, `d_dfp_write`, `d_dfp_wdata`, `d_dfp_rdata`, `d_dfp_resp`: same as the i-cache set, for the d-cache.
- `bmem_addr` out 32: line address, `{addr[31:5],5'b0}`.
- `bmem_read` out 1: one-cycle read burst command.
- `bmem_write` out 1: write beat valid; held high for each beat.
- `bmem_wdata` out 64: current write beat.
- `bmem_ready` in 1: memory accepts a command or write beat this cycle.
- `bmem_raddr` in 32: address tag of the read beat (checked only under assertions).
- `bmem_rdata` in 64: read beat.
- `bmem_rvalid` in 1: read beat valid.

## Operation
- Requesters hold `read`/`write` and the address stable until they see `resp`. At most one burst is outstanding.
- States:
  - IDLE: sample requests; if any are present, latch the winner's id, address, direction and wdata, then go to RD_CMD (read) or WR_BEAT (write).
  - RD_CMD: drive `bmem_read=1` and `bmem_addr`; when `bmem_ready`, go to RD_BEAT, else stay.
  - RD_BEAT: each `bmem_rvalid` stores `bmem_rdata` into beat slot `cnt` (beat 0 = bits [63:0]) and increments `cnt`; the 4th beat goes to DONE.
  - WR_BEAT: drive `bmem_write=1`, `bmem_addr`, and `bmem_wdata` = beat `cnt` of the latched line; each cycle with `bmem_ready` increments `cnt`; after beat 3 is accepted, go to DONE.
  - DONE: pulse the granted cache's `resp` for exactly one cycle, drive its `rdata` from the line buffer, then go to IDLE.
- Non-granted `resp` is always 0.
- `rdata` to both caches is the line buffer. Its value is only meaningful while `resp` is high.
- `cnt` is 2 bits and wraps 3→0. It is cleared on entry to RD_CMD and WR_BEAT.
- If a requester asserts `read` and `write` together, the write is taken (write-back before alloc).
- `bmem_rvalid` outside RD_BEAT is ignored.
- Requests arriving in non-IDLE states wait; they are never dropped.
- The granted requester's still-high request during DONE is not re-sampled. IDLE always spends one cycle before a new grant.

## Timing
- Reset values: all outputs 0, line buffer 0, state IDLE, `cnt` 0, round-robin pointer to d-cache.
- Reset mid-burst aborts the burst immediately: no `resp` and no further bmem activity.
- Read with a ready memory: cycle 0 grant (IDLE), cycle 1 `bmem_read`, beats on cycles k..k+3, `resp` on cycle k+4.
- Write with a ready memory: cycle 0 grant, cycles 1–4 beats, cycle 5 `resp`. Each `bmem_ready`=0 cycle adds one cycle.
- Back-to-back service: the next grant comes at the earliest 1 cycle after `resp`.

## Configuration
- `ARB_ROUND_ROBIN_EN`:
  - Defined: on simultaneous requests in IDLE, the cache not served last wins; the pointer updates on each grant.
  - Undefined: fixed priority, d-cache always wins; the i-cache can starve while the d-cache keeps requesting.

## Structure
- Package `rv32i_types`: enum `arb_state_t` {IDLE, RD_CMD, RD_BEAT, WR_BEAT, DONE}, `arb_req_t` {I_REQ, D_REQ}, and localparams `LINE_WIDTH`=256, `BEAT_WIDTH`, `BURST_LEN`.
- One sub-module, `line_beat_buffer`: a 256-bit register with beat-indexed write (`rdata` deserialize), parallel load (`wdata` latch) and beat-indexed read mux.
- Assertions (simulation only): `bmem_raddr` matches the latched address on each beat; `BEAT_WIDTH*BURST_LEN==256`.

## Test plan
- d-cache read of 0x0000_1040; memory returns beats 0x11..,0x22..,0x33..,0x44.. → `bmem_addr`=0x0000_1040, one `bmem_read`, `d_dfp_rdata`={beat3,beat2,beat1,beat0}, one `d_dfp_resp`, `i_dfp_resp`=0.
- d-cache write of line 0xAAAA…_0123 to 0x2000 with `bmem_ready` low on beat 2 for 3 cycles → 4 beats in order, beat 2 held stable, `resp` on cycle 8.
- i- and d-cache read in the same cycle → d served first.
  - With `ARB_ROUND_ROBIN_EN`, a repeated collision next grants i.
  - Without it, d always wins.
- d-cache write-back then alloc (write `resp` followed by read the next cycle) while the i-cache waits → order is d-write, then i-read (RR) or d-read (fixed); no request is lost.
- `rst`=0 during RD_BEAT after 2 beats → all outputs 0 the next cycle, no `resp`; a new read after reset completes normally.
- Spurious `bmem_rvalid` in IDLE → no state change, no `resp`.
